// File: rtl/aes_inv_core_pkg.sv
// Shared constants for the AES-128 inverse cipher: S-box tables, Rcon, FSM states and GF helpers.
package aes_inv_core_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ROUND  = 2'd1,
        ST_DONE   = 2'd2,
        ST_KEYEXP = 2'd3
    } fsm_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] r;
        r = 8'h00;
        case (idx)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // RotWord moves byte 1 into byte 0; bytes sit little-end first in the word.
    function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
        logic [31:0] rot;
        logic [31:0] res;
        rot = {w[7:0], w[31:8]};
        for (int i = 0; i < 4; i++) res[8*i +: 8] = SBOX[rot[8*i +: 8]];
        return res;
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
        logic [7:0] a  [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int i = 0; i < 4; i++) begin
            a[i]  = w[8*i +: 8];
            x2[i] = xtime(a[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
            m9[i] = x8[i] ^ a[i];
            mb[i] = x8[i] ^ x2[i] ^ a[i];
            md[i] = x8[i] ^ x4[i] ^ a[i];
            me[i] = x8[i] ^ x4[i] ^ x2[i];
        end
        return {mb[0] ^ md[1] ^ m9[2] ^ me[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                me[0] ^ mb[1] ^ md[2] ^ m9[3]};
    endfunction

endpackage

// File: rtl/aes_inv_core_round.sv
// One combinational inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns
// unless last_round_i bypasses it.
module aes_inv_round
    import aes_inv_core_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] rk_i,
    input  logic         last_round_i,
    output logic [127:0] state_o
);

    logic [127:0] sub_w;
    logic [127:0] ark_w;
    logic [127:0] mix_w;

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            // Row r rotates right by r: destination column c reads source column (c-r) mod 4.
            localparam int SRC = r + 4 * ((c - r + 4) % 4);
            assign sub_w[8*(r+4*c) +: 8] = INV_SBOX[state_i[8*SRC +: 8]];
        end
        assign mix_w[32*c +: 32] = inv_mix_col(ark_w[32*c +: 32]);
    end

    assign ark_w   = sub_w ^ rk_i;
    assign state_o = last_round_i ? ark_w : mix_w;

endmodule

// File: rtl/aes_inv_core.sv
// Iterative AES-128 inverse cipher, one round per enabled cycle, valid/ready on both sides.
// AES_INV_KEYEXP_EN: in_key is the cipher key and a forward key-expansion phase precedes the rounds.
module aes_inv_core
    import aes_inv_core_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         clk_en,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    localparam logic [3:0] RND_LAST = 4'(NR - 1);

    // Walk the schedule backwards: rk holds round rnd+1, result is round rnd.
    function automatic logic [127:0] key_prev(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w3 = rk[127:96] ^ rk[95:64];
        w2 = rk[95:64]  ^ rk[63:32];
        w1 = rk[63:32]  ^ rk[31:0];
        w0 = rk[31:0] ^ sub_rot_word(w3) ^ {24'h0, rc};
        return {w3, w2, w1, w0};
    endfunction

`ifdef AES_INV_KEYEXP_EN
    function automatic logic [127:0] key_next(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n0 = rk[31:0] ^ sub_rot_word(rk[127:96]) ^ {24'h0, rc};
        n1 = rk[63:32]  ^ n0;
        n2 = rk[95:64]  ^ n1;
        n3 = rk[127:96] ^ n2;
        return {n3, n2, n1, n0};
    endfunction
`endif

    fsm_e         fsm_q, fsm_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] state_q, state_d;
    logic [127:0] rk_q, rk_d;
    logic [127:0] rk_prev;
    logic [127:0] round_out;

    assign rk_prev = key_prev(rk_q, rcon(rnd_q + 4'd1));

`ifdef AES_INV_KEYEXP_EN
    logic [127:0] rk_next;
    assign rk_next = key_next(rk_q, rcon(rnd_q));
`endif

    aes_inv_round u_round (
        .state_i      (state_q),
        .rk_i         (rk_prev),
        .last_round_i (rnd_q == 4'd0),
        .state_o      (round_out)
    );

    always_comb begin
        fsm_d   = fsm_q;
        rnd_d   = rnd_q;
        state_d = state_q;
        rk_d    = rk_q;
        case (fsm_q)
            ST_IDLE: begin
                if (in_valid) begin
                    rk_d = in_key;
`ifdef AES_INV_KEYEXP_EN
                    // Ciphertext parks in the state register while the key is expanded.
                    state_d = in_data;
                    rnd_d   = 4'd1;
                    fsm_d   = ST_KEYEXP;
`else
                    state_d = in_data ^ in_key;
                    rnd_d   = RND_LAST;
                    fsm_d   = ST_ROUND;
`endif
                end
            end
`ifdef AES_INV_KEYEXP_EN
            ST_KEYEXP: begin
                rk_d = rk_next;
                if (rnd_q == 4'(NR)) begin
                    state_d = state_q ^ rk_next;
                    rnd_d   = RND_LAST;
                    fsm_d   = ST_ROUND;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
`endif
            ST_ROUND: begin
                state_d = round_out;
                rk_d    = rk_prev;
                if (rnd_q == 4'd0) fsm_d = ST_DONE;
                else               rnd_d = rnd_q - 4'd1;
            end
            ST_DONE: begin
                if (out_ready) fsm_d = ST_IDLE;
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= ST_IDLE;
            rnd_q   <= '0;
            state_q <= '0;
            rk_q    <= '0;
        end else if (clk_en) begin
            fsm_q   <= fsm_d;
            rnd_q   <= rnd_d;
            state_q <= state_d;
            rk_q    <= rk_d;
        end
    end

    assign in_ready  = (fsm_q == ST_IDLE);
    assign out_valid = (fsm_q == ST_DONE);
    assign out_data  = out_valid ? state_q : '0;

endmodule

// File: tb/tb_aes_inv_core.sv
// Self-checking bench for aes_inv_core: FIPS-197 vectors, backpressure, clock-enable gaps,
// mid-run reset and random blocks against a from-first-principles AES decrypt model.
module tb_aes_inv_core;

`ifdef AES_INV_KEYEXP_EN
    localparam int LAT = 21;
`else
    localparam int LAT = 11;
`endif

    logic         clk, clk_en, rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [127:0] in_data, in_key, out_data;
    int           total = 0;
    int           bad   = 0;

    logic [7:0]   m_sb  [256];
    logic [7:0]   m_isb [256];
    logic [127:0] m_rk  [11];

    aes_inv_core dut (
        .clk       (clk),
        .clk_en    (clk_en),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from the GF(2^8) inverse plus affine transform; inverse table by inversion.
    task automatic build_sbox();
        logic [7:0] inv, t, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv;
            t = inv;
            for (int k = 0; k < 4; k++) begin
                t = {t[6:0], t[7]};
                s ^= t;
            end
            s ^= 8'h63;
            m_sb[x]  = s;
            m_isb[s] = 8'(x);
        end
    endtask

    task automatic expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[7:0], t[31:8]};
                for (int b = 0; b < 4; b++) t[8*b +: 8] = m_sb[t[8*b +: 8]];
                t[7:0] ^= rc;
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) m_rk[r] = {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]};
    endtask

    function automatic logic [127:0] model_dec(input logic [127:0] ct);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) s[i] = ct[8*i +: 8] ^ m_rk[10][8*i +: 8];
        for (int rd = 9; rd >= 0; rd--) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[r + 4*((c + r) % 4)] = s[r + 4*c];
            for (int i = 0; i < 16; i++) s[i] = m_isb[t[i]] ^ m_rk[rd][8*i +: 8];
            if (rd > 0) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
                    s[4*c+1] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
                    s[4*c+2] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
                    s[4*c+3] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
                end
            end
        end
        for (int i = 0; i < 16; i++) res[8*i +: 8] = s[i];
        return res;
    endfunction

    // FIPS hex strings list byte 0 first; the bus carries byte 0 in the low bits.
    function automatic logic [127:0] bs(input logic [127:0] h);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = h[8*(15-i) +: 8];
        return r;
    endfunction

    function automatic logic [127:0] pick_key(input logic [127:0] cipher_key, input logic [127:0] rk10);
`ifdef AES_INV_KEYEXP_EN
        return cipher_key;
`else
        return rk10;
`endif
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [131:0] obs, input logic [131:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Latency counts enabled edges from the accept edge (inclusive) to the edge raising out_valid.
    task automatic run_block(input logic [127:0] key, input logic [127:0] ct, input logic [127:0] exp,
                             input string tag, input bit rnd_en, input int bp);
        int           n, guard;
        bit           en;
        logic [129:0] snap;
        logic [127:0] held;
        clk_en = 1'b1;
        guard  = 0;
        while (!in_ready && guard < 100) begin step(); guard++; end
        chk({tag, "_in_ready"}, 132'(in_ready), 132'(1));
        in_valid = 1'b1;
        in_data  = ct;
        in_key   = key;
        step();
        n        = 1;
        in_valid = 1'b0;
        in_data  = rnd128();
        in_key   = rnd128();
        guard    = 0;
        while (!out_valid && guard < 400) begin
            en     = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
            clk_en = en;
            snap   = {in_ready, out_valid, out_data};
            step();
            guard++;
            if (en) n++;
            else chk({tag, "_frozen"}, 132'({in_ready, out_valid, out_data}), 132'(snap));
        end
        clk_en = 1'b1;
        chk({tag, "_latency"}, 132'(n), 132'(LAT));
        chk({tag, "_pt"}, {3'b0, out_valid, out_data}, {3'b0, 1'b1, exp});
        held      = out_data;
        out_ready = 1'b0;
        for (int i = 0; i < bp; i++) begin
            in_valid = 1'b1;
            in_data  = rnd128();
            clk_en   = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
            chk({tag, "_hold"}, 132'({out_valid, in_ready, out_data}), 132'({1'b1, 1'b0, held}));
        end
        in_valid = 1'b0;
        if (rnd_en) begin
            out_ready = 1'b1;
            clk_en    = 1'b0;
            step();
            chk({tag, "_done_frozen"}, 132'({out_valid, out_data}), 132'({1'b1, held}));
        end
        out_ready = 1'b1;
        clk_en    = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_to_idle"}, 132'({in_ready, out_valid}), 132'(2'b10));
    endtask

    initial begin
        logic [127:0] key, ct, pt_c1, ct_c1, key_c1, pt_b, ct_b, key_b;
        build_sbox();
        pt_c1  = bs(128'h00112233445566778899aabbccddeeff);
        ct_c1  = bs(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        key_c1 = pick_key(bs(128'h000102030405060708090a0b0c0d0e0f),
                          bs(128'h13111d7fe3944a17f307a78b4d2b30c5));
        pt_b   = bs(128'h3243f6a8885a308d313198a2e0370734);
        ct_b   = bs(128'h3925841d02dc09fbdc118597196a0b32);
        key_b  = pick_key(bs(128'h2b7e151628aed2a6abf7158809cf4f3c),
                          bs(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));

        rst_n = 1'b0; clk_en = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_key = '0;
        step();
        step();
        chk("reset_state", 132'({in_ready, out_valid, out_data}), 132'({1'b1, 1'b0, 128'h0}));
        rst_n = 1'b1;
        step();

        run_block(key_c1, ct_c1, pt_c1, "fips_c1", 1'b0, 0);
        run_block(key_b, ct_b, pt_b, "fips_b_bp", 1'b0, 5);
        run_block(key_c1, ct_c1, pt_c1, "fips_c1_clken", 1'b1, 2);

        // Abort mid-decrypt with reset, then make sure the next block is unaffected.
        in_valid = 1'b1; in_data = ct_b; in_key = key_b; clk_en = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        chk("mid_reset", 132'({in_ready, out_valid, out_data}), 132'({1'b1, 1'b0, 128'h0}));
        @(negedge clk);
        rst_n = 1'b1;
        step();
        run_block(key_c1, ct_c1, pt_c1, "after_reset", 1'b0, 0);

        for (int k = 0; k < 6; k++) begin
            key = rnd128();
            ct  = rnd128();
            expand(key);
            run_block(pick_key(key, m_rk[10]), ct, model_dec(ct), $sformatf("rand%0d", k),
                      1'(k % 2), int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
